k054000_seq: RTL and testbench
==============================

Name: k054000_seq

Overview:
- CPU-facing sequencer that time-multiplexes one shared k054000_unit across up to three axes (X, Y, Z).
- Holds the per-axis operand register file and runs one axis comparison per two clocks on a start command.
- ORs the per-axis RESULTs into one latched status: 1 = separated/no hit, 0 = hit.
- Sits between the CPU bus decode and a single k054000_unit instance.

Parameters:
AXES, 3, number of axes evaluated per start (1..3); axis n registers exist for n < AXES only.

Ports:
CLK  in  1  system clock, all state updates on rising edge
nRES  in  1  asynchronous active-low reset
ADDR  in  5  register address
DIN  in  8  write data
nWR  in  1  synchronous write strobe, active low; each cycle low = one write
DOUT  out  8  read data, combinational from ADDR
BUSY  out  1  sequence in progress
DONE  out  1  one-cycle pulse when RESULT updates
RESULT  out  1  latched combined result (1 = no hit)
U_VAL_A  out  24  to unit VAL_A (registered)
U_VAL_B  out  24  to unit VAL_B (registered)
U_VAL_C  out  8  to unit VAL_C (registered)
U_VAL_D  out  8  to unit VAL_D (registered)
U_VAL_E  out  8  to unit VAL_E (registered)
U_RESULT  in  1  unit RESULT

Behaviour:
- Reset: all operand registers, U_VAL_*, BUSY, DONE, RESULT and VALID are 0; state IDLE.
- Register map, axis n base = 9*n:
  - +0..+2: A, LSB first
  - +3..+5: B, LSB first
  - +6: C; +7: D; +8: E
- 0x1F CTRL: a write with any data is START. A read returns {5'b0, VALID, BUSY, RESULT}.
- Reads of unimplemented addresses (axis n >= AXES, 27..30) return 0; writes to them are ignored.
- States: IDLE -> LOAD(n) -> EVAL(n) -> LOAD(n+1) ... -> IDLE.
- Edge E0, START accepted:
  - BUSY <= 1, VALID <= 0, acc <= 0, axis <= 0.
  - State goes to LOAD.
- LOAD edge: U_VAL_* <= the operands of the current axis; state goes to EVAL.
- EVAL edge:
  - acc <= acc | U_RESULT.
  - If axis == AXES-1: BUSY <= 0, RESULT <= acc | U_RESULT, VALID <= 1, DONE <= 1 for exactly one cycle, state goes to IDLE.
  - Otherwise axis++ and state goes to LOAD.
- Latency with AXES=3: BUSY high 6 cycles (E1..E6); DONE high in the cycle after E6.
- U_VAL_* hold their last values in IDLE; the unit is combinational, so one LOAD cycle is the settle time.
- START while BUSY: restarts from axis 0 and clears acc. RESULT keeps its old value; VALID is 0.
- Operand write while BUSY:
  - The register updates.
  - The sequence aborts: BUSY <= 0, VALID stays 0, no DONE, RESULT unchanged.
- Operand write while IDLE: VALID <= 0 (stale result). RESULT keeps its value.
- Reset mid-sequence: immediate return to the reset state with no DONE.
- No arithmetic in this block. Operands pass unmodified; width and sign rules belong to the unit.

Optional Feature:
K054000_SEQ_EARLY_EXIT_EN
- Defined: at an EVAL edge with U_RESULT = 1, finish immediately as if it were the last axis. RESULT = 1, DONE pulses, remaining axes are skipped. With the X axis separated, BUSY is high for 2 cycles.
- Undefined: every start evaluates all AXES axes. Latency is fixed at 2*AXES cycles.

Test Plan:
- Reset → BUSY=0, DONE=0, RESULT=0, U_VAL_*=0, read 0x1F = 0x00.
- All axes A=0x000100, B=0x000100, C=D=0x10, E=0, START (no macro) → BUSY 6 cycles; DONE 1 cycle; RESULT=0; read 0x1F = 0x04.
- Same setup but axis X B=0x000200 → RESULT=1, DONE after 6 cycles. With K054000_SEQ_EARLY_EXIT_EN: DONE after 2 cycles and U_VAL_* never take the Y operands.
- START, then write axis Y C=0x30 on the 3rd BUSY cycle → BUSY drops the next cycle, no DONE, VALID=0, RESULT unchanged, register readback 0x30.
- START, then START again on the 4th BUSY cycle → a full 6-cycle sequence from the second START, exactly one DONE.
- AXES=1: START → BUSY 2 cycles; reads of 9..26 return 0; writes to them ignored.

Source files
------------

// File: rtl/k054000_seq.sv
// rtl/k054000_seq.sv - CPU sequencer sharing one k054000_unit across AXES axes; optional early exit via K054000_SEQ_EARLY_EXIT_EN
module k054000_seq #(
  parameter int AXES = 3
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic [4:0]  ADDR,
  input  logic [7:0]  DIN,
  input  logic        nWR,
  output logic [7:0]  DOUT,
  output logic        BUSY,
  output logic        DONE,
  output logic        RESULT,
  output logic [23:0] U_VAL_A,
  output logic [23:0] U_VAL_B,
  output logic [7:0]  U_VAL_C,
  output logic [7:0]  U_VAL_D,
  output logic [7:0]  U_VAL_E,
  input  logic        U_RESULT
);

  localparam logic [1:0] LAST_AXIS = 2'(AXES - 1);
  localparam logic [2:0] NUM_AXES  = 3'(AXES);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL} state_t;

  state_t      state, state_nxt;
  logic [23:0] a_r [0:2];
  logic [23:0] b_r [0:2];
  logic [7:0]  c_r [0:2];
  logic [7:0]  d_r [0:2];
  logic [7:0]  e_r [0:2];
  logic [1:0]  sel_axis;
  logic [3:0]  sel_off;
  logic        sel_ok;
  logic        wr_op, wr_start;
  logic        valid, acc;
  logic [1:0]  axis;
  logic        do_load, do_eval, do_step, do_finish;
  logic        early;

  // A separated axis settles the combined result, so later axes can be skipped
  always_comb begin
`ifdef K054000_SEQ_EARLY_EXIT_EN
    early = U_RESULT;
`else
    early = 1'b0;
`endif
  end

  // Address decode: three 9-byte axis windows, unimplemented axes masked off
  always_comb begin
    sel_axis = 2'd0;
    sel_off  = 4'd0;
    sel_ok   = 1'b0;
    if (ADDR < 5'd9) begin
      sel_axis = 2'd0;
      sel_off  = ADDR[3:0];
      sel_ok   = 1'b1;
    end else if (ADDR < 5'd18) begin
      sel_axis = 2'd1;
      sel_off  = 4'(ADDR - 5'd9);
      sel_ok   = 1'b1;
    end else if (ADDR < 5'd27) begin
      sel_axis = 2'd2;
      sel_off  = 4'(ADDR - 5'd18);
      sel_ok   = 1'b1;
    end
    if ({1'b0, sel_axis} >= NUM_AXES) sel_ok = 1'b0;
  end

  assign wr_op    = !nWR && sel_ok;
  assign wr_start = !nWR && (ADDR == 5'h1F);
  assign BUSY     = (state != IDLE);

  // Combinational read mux
  always_comb begin
    DOUT = 8'h00;
    if (ADDR == 5'h1F) begin
      DOUT = {5'b0, valid, BUSY, RESULT};
    end else if (sel_ok) begin
      case (sel_off)
        4'd0:    DOUT = a_r[sel_axis][7:0];
        4'd1:    DOUT = a_r[sel_axis][15:8];
        4'd2:    DOUT = a_r[sel_axis][23:16];
        4'd3:    DOUT = b_r[sel_axis][7:0];
        4'd4:    DOUT = b_r[sel_axis][15:8];
        4'd5:    DOUT = b_r[sel_axis][23:16];
        4'd6:    DOUT = c_r[sel_axis];
        4'd7:    DOUT = d_r[sel_axis];
        4'd8:    DOUT = e_r[sel_axis];
        default: DOUT = 8'h00;
      endcase
    end
  end

  // Next-state: START restarts, operand write aborts, else LOAD/EVAL alternate
  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_eval   = 1'b0;
    do_step   = 1'b0;
    do_finish = 1'b0;
    if (wr_start) begin
      state_nxt = LOAD;
    end else if (wr_op && state != IDLE) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        LOAD: begin
          do_load   = 1'b1;
          state_nxt = EVAL;
        end
        EVAL: begin
          do_eval = 1'b1;
          if (axis == LAST_AXIS || early) begin
            do_finish = 1'b1;
            state_nxt = IDLE;
          end else begin
            do_step   = 1'b1;
            state_nxt = LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) state <= IDLE;
    else       state <= state_nxt;
  end

  // Accumulator, axis counter and CPU-visible status
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      acc    <= 1'b0;
      axis   <= 2'd0;
      valid  <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= 1'b0;
    end else begin
      DONE <= do_finish;
      if (wr_start) begin
        acc   <= 1'b0;
        axis  <= 2'd0;
        valid <= 1'b0;
      end else begin
        if (wr_op)     valid <= 1'b0;
        if (do_eval)   acc   <= acc | U_RESULT;
        if (do_step)   axis  <= axis + 2'd1;
        if (do_finish) begin
          RESULT <= acc | U_RESULT;
          valid  <= 1'b1;
        end
      end
    end
  end

  // Present the current axis operands to the shared unit
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      U_VAL_A <= '0;
      U_VAL_B <= '0;
      U_VAL_C <= '0;
      U_VAL_D <= '0;
      U_VAL_E <= '0;
    end else if (do_load) begin
      U_VAL_A <= a_r[axis];
      U_VAL_B <= b_r[axis];
      U_VAL_C <= c_r[axis];
      U_VAL_D <= d_r[axis];
      U_VAL_E <= e_r[axis];
    end
  end

  // Operand register file, byte-wide CPU writes
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      for (int i = 0; i < 3; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
        c_r[i] <= '0;
        d_r[i] <= '0;
        e_r[i] <= '0;
      end
    end else if (wr_op) begin
      case (sel_off)
        4'd0:    a_r[sel_axis][7:0]   <= DIN;
        4'd1:    a_r[sel_axis][15:8]  <= DIN;
        4'd2:    a_r[sel_axis][23:16] <= DIN;
        4'd3:    b_r[sel_axis][7:0]   <= DIN;
        4'd4:    b_r[sel_axis][15:8]  <= DIN;
        4'd5:    b_r[sel_axis][23:16] <= DIN;
        4'd6:    c_r[sel_axis]        <= DIN;
        4'd7:    d_r[sel_axis]        <= DIN;
        4'd8:    e_r[sel_axis]        <= DIN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_k054000_seq.sv
// tb/tb_k054000_seq.sv - self-checking bench for k054000_seq (AXES=3 and AXES=1 instances)
module tb_k054000_seq;

  logic        CLK = 1'b0;
  logic        nRES;
  logic [4:0]  ADDR;
  logic [7:0]  DIN;
  logic        nWR;

  logic [7:0]  dout3, dout1;
  logic        busy3, busy1, done3, done1, res3, res1, ur3, ur1;
  logic [23:0] va3, vb3, va1, vb1;
  logic [7:0]  vc3, vd3, ve3, vc1, vd1, ve1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int busy;
    int done_cnt;
    int done_cyc;
    int result;
    int ctrl;
    int last_axis;
    int first_sep;
  } exp_t;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic [7:0] exp3;
    logic [7:0] exp1;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];

  logic [23:0] sa[3];
  logic [23:0] sbv[3];
  logic [7:0]  sc[3];
  logic [7:0]  sd[3];

  // clock
  always #5 CLK = ~CLK;

  // stand-in unit: separated when |A-B| exceeds C+D
  function automatic logic sep(input logic [23:0] a, input logic [23:0] b,
                               input logic [7:0] c, input logic [7:0] d);
    int diff;
    diff = (a > b) ? int'(a - b) : int'(b - a);
    return diff > (int'(c) + int'(d));
  endfunction

  assign ur3 = sep(va3, vb3, vc3, vd3);
  assign ur1 = sep(va1, vb1, vc1, vd1);

  k054000_seq #(.AXES(3)) dut3 (
    .CLK(CLK), .nRES(nRES), .ADDR(ADDR), .DIN(DIN), .nWR(nWR),
    .DOUT(dout3), .BUSY(busy3), .DONE(done3), .RESULT(res3),
    .U_VAL_A(va3), .U_VAL_B(vb3), .U_VAL_C(vc3), .U_VAL_D(vd3), .U_VAL_E(ve3),
    .U_RESULT(ur3)
  );

  k054000_seq #(.AXES(1)) dut1 (
    .CLK(CLK), .nRES(nRES), .ADDR(ADDR), .DIN(DIN), .nWR(nWR),
    .DOUT(dout1), .BUSY(busy1), .DONE(done1), .RESULT(res1),
    .U_VAL_A(va1), .U_VAL_B(vb1), .U_VAL_C(vc1), .U_VAL_D(vd1), .U_VAL_E(ve1),
    .U_RESULT(ur1)
  );

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge CLK);
    ADDR = a;
    DIN  = d;
    nWR  = 1'b0;
    @(negedge CLK);
    nWR  = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d3, output logic [7:0] d1);
    ADDR = a;
    #1;
    d3 = dout3;
    d1 = dout1;
  endtask

  task automatic set_axis(input int n, input logic [23:0] a, input logic [23:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
    logic [4:0] base;
    base = 5'(9 * n);
    wr(base + 5'd0, a[7:0]);
    wr(base + 5'd1, a[15:8]);
    wr(base + 5'd2, a[23:16]);
    wr(base + 5'd3, b[7:0]);
    wr(base + 5'd4, b[15:8]);
    wr(base + 5'd5, b[23:16]);
    wr(base + 5'd6, c);
    wr(base + 5'd7, d);
    wr(base + 5'd8, e);
    sa[n] = a; sbv[n] = b; sc[n] = c; sd[n] = d;
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.first_sep = -1;
    e.result = 0;
    for (int n = 0; n < 3; n++)
      if (sep(sa[n], sbv[n], sc[n], sd[n])) begin
        e.result = 1;
        if (e.first_sep < 0) e.first_sep = n;
      end
    e.busy = 6;
    e.last_axis = 2;
`ifdef K054000_SEQ_EARLY_EXIT_EN
    if (e.first_sep >= 0) begin
      e.busy = 2 * (e.first_sep + 1);
      e.last_axis = e.first_sep;
    end
`endif
    e.done_cnt = 1;
    e.done_cyc = e.busy + 1;
    e.ctrl = 4 + e.result;
    return e;
  endfunction

  // START, then watch 16 cycles; optional action (1 = write, 2 = START) at busy cycle act_at
  task automatic watch(input int act_at, input int act_kind, input logic [4:0] act_addr,
                       input logic [7:0] act_data,
                       output int b3, output int d3, output int c3,
                       output int b1, output int d1, output int c1);
    b3 = 0; d3 = 0; c3 = 0; b1 = 0; d1 = 0; c1 = 0;
    @(negedge CLK);
    ADDR = 5'h1F;
    DIN  = 8'h00;
    nWR  = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge CLK);
      nWR = 1'b1;
      if (busy3) b3++;
      if (done3) begin d3++; c3 = cyc; end
      if (busy1) b1++;
      if (done1) begin d1++; c1 = cyc; end
      if (cyc == act_at && act_kind != 0) begin
        ADDR = (act_kind == 2) ? 5'h1F : act_addr;
        DIN  = act_data;
        nWR  = 1'b0;
      end
    end
  endtask

  task automatic run_plain(input string name);
    exp_t e;
    int b3, d3, c3, b1, d1, c1;
    logic [7:0] r3, r1;
    sb.push_back(predict());
    watch(0, 0, 5'd0, 8'd0, b3, d3, c3, b1, d1, c1);
    e = sb.pop_front();
    chk({name, " busy3"}, b3, e.busy);
    chk({name, " done3_cnt"}, d3, e.done_cnt);
    chk({name, " done3_cyc"}, c3, e.done_cyc);
    chk({name, " result3"}, res3, e.result);
    chk({name, " u_val_a"}, va3, sa[e.last_axis]);
    chk({name, " u_val_b"}, vb3, sbv[e.last_axis]);
    chk({name, " u_val_c"}, vc3, sc[e.last_axis]);
    chk({name, " busy1"}, b1, 2);
    chk({name, " done1_cyc"}, c1, 3);
    chk({name, " result1"}, res1, sep(sa[0], sbv[0], sc[0], sd[0]));
    rd(5'h1F, r3, r1);
    chk({name, " ctrl3"}, r3, e.ctrl);
    chk({name, " ctrl1"}, r1, 4 + sep(sa[0], sbv[0], sc[0], sd[0]));
  endtask

  initial begin
    logic [7:0] r3, r1;
    int b3, d3, c3, b1, d1, c1;
    exp_t e;

    vecs[0] = '{5'd0,  8'h11, 8'h11, 8'h11};
    vecs[1] = '{5'd2,  8'h22, 8'h22, 8'h22};
    vecs[2] = '{5'd8,  8'h33, 8'h33, 8'h33};
    vecs[3] = '{5'd9,  8'h44, 8'h44, 8'h00};
    vecs[4] = '{5'd17, 8'h55, 8'h55, 8'h00};
    vecs[5] = '{5'd26, 8'h66, 8'h66, 8'h00};
    vecs[6] = '{5'd27, 8'h77, 8'h00, 8'h00};
    vecs[7] = '{5'd30, 8'h88, 8'h00, 8'h00};

    nRES = 1'b0; ADDR = 5'd0; DIN = 8'd0; nWR = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst busy", busy3, 0);
    chk("rst done", done3, 0);
    chk("rst result", res3, 0);
    chk("rst u_val_a", va3, 0);
    chk("rst u_val_b", vb3, 0);
    chk("rst u_val_cde", {vc3, vd3, ve3}, 0);
    rd(5'h1F, r3, r1);
    chk("rst ctrl3", r3, 0);
    chk("rst ctrl1", r1, 0);
    nRES = 1'b1;

    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      rd(vecs[i].addr, r3, r1);
      chk($sformatf("rb3 addr%0d", vecs[i].addr), r3, vecs[i].exp3);
      chk($sformatf("rb1 addr%0d", vecs[i].addr), r1, vecs[i].exp1);
    end

    for (int n = 0; n < 3; n++) set_axis(n, 24'h000100, 24'h000100, 8'h10, 8'h10, 8'h00);
    run_plain("all_hit");

    set_axis(0, 24'h000100, 24'h000200, 8'h10, 8'h10, 8'h00);
    run_plain("x_sep");

    set_axis(0, 24'h000100, 24'h000100, 8'h10, 8'h10, 8'h00);
    set_axis(1, 24'h000100, 24'h000300, 8'h10, 8'h10, 8'h00);
    run_plain("y_sep");

    // abort: Y operands restored to hit, RESULT is 1 from the previous run
    set_axis(1, 24'h000100, 24'h000100, 8'h10, 8'h10, 8'h00);
    watch(3, 1, 5'd15, 8'h30, b3, d3, c3, b1, d1, c1);
    sc[1] = 8'h30;
    chk("abort busy3", b3, 3);
    chk("abort done3", d3, 0);
    rd(5'h1F, r3, r1);
    chk("abort ctrl3", r3, 8'h01);
    rd(5'd15, r3, r1);
    chk("abort readback", r3, 8'h30);

    // restart on the 4th busy cycle
    e = predict();
    e.busy = 4 + e.busy;
    e.done_cyc = e.busy + 1;
    sb.push_back(e);
    watch(4, 2, 5'd0, 8'd0, b3, d3, c3, b1, d1, c1);
    e = sb.pop_front();
    chk("restart busy3", b3, e.busy);
    chk("restart done3_cnt", d3, 1);
    chk("restart done3_cyc", c3, e.done_cyc);
    chk("restart result3", res3, e.result);
    rd(5'h1F, r3, r1);
    chk("restart ctrl3", r3, e.ctrl);

    // reset in the middle of a sequence
    @(negedge CLK);
    ADDR = 5'h1F; nWR = 1'b0;
    @(negedge CLK);
    nWR = 1'b1;
    @(negedge CLK);
    chk("midrst busy_before", busy3, 1);
    #1 nRES = 1'b0;
    #1;
    chk("midrst busy", busy3, 0);
    chk("midrst done", done3, 0);
    chk("midrst u_val_a", va3, 0);
    chk("midrst u_val_c", vc3, 0);
    rd(5'd0, r3, r1);
    chk("midrst reg0", r3, 0);
    @(negedge CLK);
    nRES = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("midrst no_done", done3, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
